// File: rtl/seq_sub_16b_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width, FSM
// encoding and the sizing helpers derived from the operand width.
package seq_sub_16b_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Number of nibble steps needed to cover an operand of the given width.
    function automatic int calc_nnib(input int width);
        return width / NIB_W;
    endfunction

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int calc_idx_w(input int width);
        int n;
        n = width / NIB_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_sub_16b_bla_sub_4b.sv
// Combinational 4-bit borrow-lookahead subtract slice.
// The subtraction a - b - bin is done as a + ~b + ~bin, so generate and
// propagate are formed on the inverted subtrahend and the carry chain is
// flattened into two-level lookahead terms. Borrow-out is the inverted
// carry-out.
module bla_sub_4b
    import seq_sub_16b_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] diff,
    output logic             bout
);

    logic [NIB_W-1:0] w_bn;
    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W-1:0] w_c;
    logic             w_cin;

    // Lookahead carries, each expressed directly in generate/propagate terms.
    // NOTE: every variable here is assigned on every evaluation, so no latch can be inferred.
    always_comb begin
        w_bn  = ~b;
        w_g   = a & w_bn;
        w_p   = a ^ w_bn;
        w_cin = ~bin;

        w_c[0] = w_g[0]
               | (w_p[0] & w_cin);
        w_c[1] = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & w_cin);
        w_c[2] = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_cin);
        w_c[3] = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cin);
    end

    assign diff = w_p ^ {w_c[2:0], w_cin};
    assign bout = ~w_c[3];

endmodule

// File: rtl/seq_sub_16b.sv
// Nibble-serial WIDTH-bit subtractor: diff = a - b - bin.
// One 4-bit lookahead slice is reused every RUN cycle, LSB nibble first,
// with the borrow carried between cycles in a register. A start/ready/done
// handshake fronts the datapath; ready is the only output decoded from
// state, everything else is registered.
module seq_sub_16b
    import seq_sub_16b_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             done
);

    localparam int NNIB  = calc_nnib(WIDTH);
    localparam int IDX_W = calc_idx_w(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_nib_diff;
    logic             w_nib_bout;

    assign ready    = (r_state == ST_IDLE);
    assign w_accept = ready & start;
    assign w_last   = (r_idx == IDX_W'(NNIB - 1));

    // Select the operand nibbles for the step currently being processed.
    assign w_a_nib = r_a[NIB_W*int'(r_idx) +: NIB_W];
    assign w_b_nib = r_b[NIB_W*int'(r_idx) +: NIB_W];

    bla_sub_4b u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .bin  (r_borrow),
        .diff (w_nib_diff),
        .bout (w_nib_bout)
    );

    // Capture the operands on accept; they are only read during RUN.
    // NOTE: pure datapath registers with no reset; they are always loaded before they are read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Handshake FSM and the per-nibble result, borrow and flag updates.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, like real flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_borrow <= bin;
                        r_idx    <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_diff[NIB_W*int'(r_idx) +: NIB_W] <= w_nib_diff;
                    r_borrow <= w_nib_bout;
                    if (w_last) begin
                        // Result MSB comes from the slice output of this final step.
                        r_bout  <= w_nib_bout;
                        r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_nib_diff[NIB_W-1] != r_a[WIDTH-1]);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign done = r_done;

endmodule

// File: tb/tb_seq_sub_16b.sv
// Directed bench for seq_sub_16b at WIDTH=16: reset state, hand-computed
// subtraction vectors, start storms while busy, and a mid-operation reset.
module tb_seq_sub_16b;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        done;

    int n_vec  = 0;
    int n_miss = 0;

    seq_sub_16b #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation; inputs are scrambled right after accept to show
    // the captured values are the ones used.
    task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin, input logic [15:0] exp_d, input logic exp_b,
                          input logic exp_o);
        int cnt;
        @(negedge clk);
        check({name, "_ready"}, 32'(ready), 32'd1);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
        cnt = 0;
        while (!done && cnt < 12) begin
            @(negedge clk);
            cnt++;
            if (ready) check({name, "_busy"}, 32'(ready), 32'd0);
        end
        check({name, "_lat"}, 32'(cnt), 32'd4);
        check({name, "_diff"}, 32'(diff), 32'(exp_d));
        check({name, "_bout"}, 32'(bout), 32'(exp_b));
        check({name, "_ovf"}, 32'(ovf), 32'(exp_o));
        @(negedge clk);
        check({name, "_pulse"}, 32'(done), 32'd0);
        check({name, "_hold"}, 32'(diff), 32'(exp_d));
        check({name, "_rdy"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [15:0] pa, pb, exp_d;
        logic        exp_b, exp_o, pending, saw_done;
        int          acc_k, n_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        run_op("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("v2", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        run_op("v3", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("v4", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("v5", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("v6", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Start held high with new operands every cycle; only requests seen
        // while ready are taken, the rest are dropped.
        pending = 1'b0; acc_k = 0; n_done = 0;
        exp_d = '0; exp_b = 1'b0; exp_o = 1'b0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("storm_pend", 32'(pending), 32'd1);
                check("storm_lat", 32'(k - acc_k), 32'd5);
                check("storm_diff", 32'(diff), 32'(exp_d));
                check("storm_bout", 32'(bout), 32'(exp_b));
                check("storm_ovf", 32'(ovf), 32'(exp_o));
                check("storm_rdy", 32'(ready), 32'd0);
                pending = 1'b0;
            end
            pa = 16'h0F00 + 16'(k) * 16'h0123;
            pb = 16'(k) * 16'h0311;
            if (ready && k < 18) begin
                acc_k   = k;
                pending = 1'b1;
                exp_d   = pa - pb;
                exp_b   = (pa < pb);
                exp_o   = (pa[15] != pb[15]) && (exp_d[15] != pa[15]);
            end
            a = pa; b = pb; bin = 1'b0;
            start = (k < 18);
        end
        start = 1'b0;
        check("storm_count", 32'(n_done), 32'd3);

        // Reset two edges into an operation: everything clears, no done.
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_ready", 32'(ready), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_diff", 32'(diff), 32'd0);
        check("mid_bout", 32'(bout), 32'd0);
        check("mid_ovf", 32'(ovf), 32'd0);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("mid_nodone", 32'(saw_done), 32'd0);

        run_op("post", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
